// File: rtl/lcd_ctrl4.sv
// HD44780-style 4-bit write-only LCD controller: power-on init, byte-to-nibble
// strobing with programmable timing, cursor tracking with automatic row wrap.
module lcd_ctrl4 #(
  parameter int COLS      = 16,
  parameter int ROWS      = 2,
  parameter int AUTO_WRAP = 1,
  parameter int SETUP_CYC = 8,
  parameter int E_CYC     = 32,
  parameter int HOLD_CYC  = 8,
  parameter int CMD_WAIT  = 5000,
  parameter int CLR_WAIT  = 205000,
  parameter int PWR_WAIT  = 2000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic [3:0] lcd_db,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP  = imax(imax(imax(SETUP_CYC, E_CYC), imax(HOLD_CYC, CMD_WAIT)),
                              imax(CLR_WAIT, PWR_WAIT));
  localparam int CNT_W = $clog2(MAXP + 1);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 1);
  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [7:0]       FUNC_SET   = (ROWS == 1) ? 8'h20 : 8'h28;

  typedef enum logic [2:0] {PWR, INIT, IDLE, SETUP, EHI, HOLD, WAIT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wait_last;
  logic [3:0]       r_step;
  logic [3:0]       r_lo_nib;
  logic             r_lo_pend;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_wrap;
  logic             r_init_done;
  logic             r_e;
  logic             r_rs;
  logic [3:0]       r_db;

  logic       w_accept;
  logic       w_ld_vld;
  logic       w_ld_rs;
  logic       w_ld_two;
  logic [7:0] w_ld_dat;
  logic       w_ld_clr;
  logic       w_in_clr;

  function automatic logic [7:0] row_base(input logic [ROW_W-1:0] r);
    case (2'(r))
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  assign in_ready  = (r_state == IDLE) && r_init_done && !r_wrap;
  assign init_done = r_init_done;
  assign lcd_db    = r_db;
  assign lcd_e     = r_e;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;

  assign w_accept = in_valid && in_ready;
  assign w_in_clr = !in_rs && (in_data == 8'h01 || in_data == 8'h02);

  // Single source for every transfer: init items, inserted wrap command, or host byte.
  // Init steps 0..3 are lone high nibbles, 4..7 full bytes.
  always_comb begin
    w_ld_vld = 1'b0;
    w_ld_rs  = 1'b0;
    w_ld_two = 1'b0;
    w_ld_dat = 8'h00;
    if (r_state == INIT && !r_step[3]) begin
      w_ld_vld = 1'b1;
      w_ld_two = r_step[2];
      case (r_step[2:0])
        3'd0, 3'd1, 3'd2: w_ld_dat = 8'h30;
        3'd3:             w_ld_dat = 8'h20;
        3'd4:             w_ld_dat = FUNC_SET;
        3'd5:             w_ld_dat = 8'h0C;
        3'd6:             w_ld_dat = 8'h06;
        default:          w_ld_dat = 8'h01;
      endcase
    end else if (r_state == IDLE && r_wrap) begin
      w_ld_vld = 1'b1;
      w_ld_two = 1'b1;
      w_ld_dat = 8'h80 | row_base(r_row);
    end else if (w_accept) begin
      w_ld_vld = 1'b1;
      w_ld_two = 1'b1;
      w_ld_rs  = in_rs;
      w_ld_dat = in_data;
    end
  end

  assign w_ld_clr = !w_ld_rs && w_ld_two && (w_ld_dat == 8'h01 || w_ld_dat == 8'h02);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= PWR;
      r_cnt       <= '0;
      r_wait_last <= '0;
      r_step      <= '0;
      r_lo_nib    <= '0;
      r_lo_pend   <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_wrap      <= 1'b0;
      r_init_done <= 1'b0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_db        <= '0;
    end else begin
      case (r_state)
        PWR: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt   <= '0;
            r_state <= INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        INIT: begin
          if (r_step[3]) begin
            r_init_done <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_step <= r_step + 4'd1;
          end
        end
        IDLE: begin
          if (r_wrap) begin
            r_wrap <= 1'b0;
          end else if (w_accept) begin
            if (w_in_clr) begin
              r_col <= '0;
              r_row <= '0;
            end else if (in_rs) begin
              if (r_col == COL_LAST) begin
                r_col  <= '0;
                r_row  <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                r_wrap <= (AUTO_WRAP != 0);
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_state <= EHI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        EHI: begin
          if (r_cnt == E_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt <= '0;
            if (r_lo_pend) begin
              r_db      <= r_lo_nib;
              r_lo_pend <= 1'b0;
              r_state   <= SETUP;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == r_wait_last) begin
            r_cnt   <= '0;
            r_state <= r_init_done ? IDLE : INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= PWR;
      endcase

      if (w_ld_vld) begin
        r_rs        <= w_ld_rs;
        r_db        <= w_ld_dat[7:4];
        r_lo_nib    <= w_ld_dat[3:0];
        r_lo_pend   <= w_ld_two;
        r_wait_last <= w_ld_clr ? CLR_LAST : CMD_LAST;
        r_cnt       <= '0;
        r_state     <= SETUP;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl4.sv
// Directed bench for lcd_ctrl4 with shortened timing: init sequence, byte
// timing, row wrap insertion, clear handling and reset during a strobe.
module tb_lcd_ctrl4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_db;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:0] q_nib[$];
  int         q_w[$];
  logic       e_prev = 1'b0;
  logic [4:0] cur_nib = 5'h00;
  int         cur_w = 0;
  int         early_cnt = 0;

  lcd_ctrl4 #(
    .COLS(16), .ROWS(2), .AUTO_WRAP(1),
    .SETUP_CYC(2), .E_CYC(4), .HOLD_CYC(2),
    .CMD_WAIT(10), .CLR_WAIT(30), .PWR_WAIT(20)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .init_done(init_done),
    .lcd_db(lcd_db), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 CLK = ~CLK;

  // Pulse recorder: {rs, nibble} latched at E rise, width counted in cycles.
  always @(negedge CLK) begin
    if (lcd_e && !e_prev) begin
      cur_nib = {lcd_rs, lcd_db};
      cur_w   = 1;
    end else if (lcd_e) begin
      cur_w++;
    end else if (e_prev) begin
      q_nib.push_back(cur_nib);
      q_w.push_back(cur_w);
    end
    if (in_ready && !init_done) early_cnt++;
    e_prev = lcd_e;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] nib_at(input int idx);
    if (idx < q_nib.size()) return q_nib[idx];
    return 5'h1F;
  endfunction

  function automatic int w_at(input int idx);
    if (idx < q_w.size()) return q_w[idx];
    return -1;
  endfunction

  task automatic wait_gap(output int gap);
    gap = 0;
    while (!in_ready && gap < 1000) begin
      gap++;
      @(negedge CLK);
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d, output int gap);
    int n = 0;
    in_rs    = rs;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    if (n == 1000) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    wait_gap(gap);
  endtask

  // Entered on the negedge where RST is released; PWR 20 + 4 nibbles x 19
  // + 3 bytes x 27 + clear 47 + final INIT cycle = 225 cycles.
  task automatic do_init(input string tag);
    int cyc;
    int base;
    int e0;
    logic [47:0] seq;
    seq = 48'h3332_280C_0601;
    #1;
    base = q_nib.size();
    e0   = early_cnt;
    cyc  = 0;
    while (!init_done && cyc < 5000) begin
      cyc++;
      @(negedge CLK);
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'd225);
    chk({tag, "_early_rdy"}, 32'(early_cnt - e0), 32'd0);
    chk({tag, "_pulses"}, 32'(q_nib.size() - base), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s_nib%0d", tag, i), 32'(nib_at(base + i)), {27'd0, 1'b0, seq[47-4*i -: 4]});
  endtask

  initial begin
    int gap;
    int base;
    logic [7:0] d;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_e", 32'(lcd_e), 32'd0);
    chk("rst_db", 32'(lcd_db), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);

    // Host holds a character throughout init.
    RST      = 1'b0;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h41;
    do_init("init1");
    chk("ready_first_idle", 32'(in_ready), 32'd1);
    base = q_nib.size();
    @(negedge CLK);
    in_valid = 1'b0;
    chk("ready_drop", 32'(in_ready), 32'd0);
    wait_gap(gap);
    chk("char_gap", 32'(gap), 32'd26);
    chk("char_pulses", 32'(q_nib.size() - base), 32'd2);
    chk("char_hi", 32'(nib_at(base)), 32'h14);
    chk("char_lo", 32'(nib_at(base + 1)), 32'h11);
    chk("char_hi_w", 32'(w_at(base)), 32'd4);
    chk("char_lo_w", 32'(w_at(base + 1)), 32'd4);
    chk("rw_const", 32'(lcd_rw), 32'd0);

    // Fill row 0 and row 1; wrap commands expected after 16th and 32nd chars.
    for (int k = 2; k <= 33; k++) begin
      d = 8'h40 + 8'(k);
      if (k == 16 || k == 32) base = q_nib.size();
      send_byte(1'b1, d, gap);
      if (k == 15) chk("gap_col15", 32'(gap), 32'd26);
      if (k == 16) chk("gap_wrap_row1", 32'(gap), 32'd53);
      if (k == 32) chk("gap_wrap_row0", 32'(gap), 32'd53);
      if (k == 17) begin
        chk("wrap_c0_pulses", 32'(q_nib.size() - base), 32'd6);
        chk("wrap_c0_hi", 32'(nib_at(base + 2)), 32'h0C);
        chk("wrap_c0_lo", 32'(nib_at(base + 3)), 32'h00);
        chk("char17_hi", 32'(nib_at(base + 4)), {27'd0, 1'b1, d[7:4]});
      end
      if (k == 33) begin
        chk("wrap_80_pulses", 32'(q_nib.size() - base), 32'd6);
        chk("wrap_80_hi", 32'(nib_at(base + 2)), 32'h08);
        chk("wrap_80_lo", 32'(nib_at(base + 3)), 32'h00);
      end
    end

    // Clear display: long wait, cursor back to 0,0.
    send_byte(1'b0, 8'h01, gap);
    chk("clr_gap", 32'(gap), 32'd46);
    base = q_nib.size();
    send_byte(1'b1, 8'h30, gap);
    chk("after_clr_gap", 32'(gap), 32'd26);
    chk("after_clr_pulses", 32'(q_nib.size() - base), 32'd2);
    chk("after_clr_hi", 32'(nib_at(base)), 32'h13);
    for (int k = 2; k <= 16; k++) begin
      send_byte(1'b1, 8'h30 + 8'(k), gap);
      if (k == 15) chk("clr_col15_gap", 32'(gap), 32'd26);
      if (k == 16) chk("clr_col16_gap", 32'(gap), 32'd53);
    end

    // Reset in the middle of an E strobe.
    in_rs    = 1'b1;
    in_data  = 8'h7E;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    gap = 0;
    while (!lcd_e && gap < 100) begin
      gap++;
      @(negedge CLK);
    end
    chk("e_high_pre_rst", 32'(lcd_e), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_e", 32'(lcd_e), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_db", 32'(lcd_db), 32'd0);
    chk("mid_rst_rs", 32'(lcd_rs), 32'd0);
    RST = 1'b0;
    do_init("init2");
    chk("ready_after_init2", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
